// File: rtl/mult4b_seq.sv
// mult4b_seq: sequential 4x4 unsigned shift-and-add multiplier driving an external 4-bit adder.
// Optional MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle with PP=0.
module mult4b_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic [3:0] MA,
    input  logic [3:0] MB,
    output logic [3:0] ADD_A,
    output logic [3:0] ADD_B,
    input  logic [3:0] ADD_S,
    input  logic       ADD_Co,
    output logic [7:0] PP,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    state_t     state;
    logic [3:0] rb, h, l;
    logic       c;
    logic [1:0] cnt;
    assign ADD_A = h;
    assign ADD_B = rb;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            PP    <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
            rb    <= 4'h0;
            h     <= 4'h0;
            l     <= 4'h0;
            c     <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (init) begin
                    rb   <= MB;
                    l    <= MA;
                    h    <= 4'h0;
                    c    <= 1'b0;
                    cnt  <= 2'd0;
                    busy <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
                    if (MA == 4'h0 || MB == 4'h0) begin
                        PP    <= 8'h00;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ADD;
                    end
`else
                    state <= ADD;
`endif
                end
                ADD: begin
                    {c, h} <= l[0] ? {ADD_Co, ADD_S} : {1'b0, h};
                    state  <= SHIFT;
                end
                SHIFT: begin
                    // Carry drops into the high nibble so the 9-bit accumulator never overflows.
                    {c, h, l} <= {1'b0, c, h, l[3:1]};
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        PP    <= {c, h, l[3:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ADD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult4b_seq.sv
// tb_mult4b_seq: randomized self-checking bench for mult4b_seq with a behavioural adder and product model.
module tb_mult4b_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [3:0] MA = 4'h0, MB = 4'h0;
    logic [3:0] ADD_A, ADD_B, ADD_S;
    logic       ADD_Co;
    logic [7:0] PP;
    logic       busy, done;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    always #5 clk = ~clk;
    assign {ADD_Co, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B};

    mult4b_seq dut (
        .clk(clk), .rst(rst), .init(init), .MA(MA), .MB(MB),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_S(ADD_S), .ADD_Co(ADD_Co),
        .PP(PP), .busy(busy), .done(done)
    );

    function automatic int lat(input logic [3:0] a, input logic [3:0] b);
        return (SKIP && (a == 4'h0 || b == 4'h0)) ? 0 : 8;
    endfunction

    // Pulses init so it is sampled at edge k; returns #1 after edge k with scrambled operands.
    task automatic start(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        MA = a; MB = b; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        MA = 4'($urandom); MB = 4'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp += 5;
        if (PP !== 8'h00) begin n_err++; $display("FAIL reset_pp got=%h exp=00", PP); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (ADD_A !== 4'h0) begin n_err++; $display("FAIL reset_add_a got=%h exp=0", ADD_A); end
        if (ADD_B !== 4'h0) begin n_err++; $display("FAIL reset_add_b got=%h exp=0", ADD_B); end
    endtask

    task automatic test_max;
        start(4'hF, 4'hF);
        for (int n = 0; n <= 10; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            n_cmp += 2;
            if (done !== (n == 8)) begin n_err++; $display("FAIL max_done n=%0d got=%b exp=%b", n, done, n == 8); end
            if (busy !== (n <= 8)) begin n_err++; $display("FAIL max_busy n=%0d got=%b exp=%b", n, busy, n <= 8); end
            if (n == 8) begin
                n_cmp++;
                if (PP !== 8'hE1) begin n_err++; $display("FAIL max_pp got=%h exp=e1", PP); end
            end
        end
    endtask

    task automatic test_hold;
        int c;
        start(4'h5, 4'h3);
        wait_done(c);
        n_cmp += 2;
        if (c !== 8) begin n_err++; $display("FAIL hold1_lat got=%0d exp=8", c); end
        if (PP !== 8'h0F) begin n_err++; $display("FAIL hold1_pp got=%h exp=0f", PP); end
        start(4'hA, 4'h6);
        c = 0;
        while (!done && c < 40) begin
            n_cmp++;
            if (PP !== 8'h0F) begin n_err++; $display("FAIL hold_keep c=%0d got=%h exp=0f", c, PP); end
            @(posedge clk); #1;
            c++;
        end
        n_cmp += 2;
        if (c !== 8) begin n_err++; $display("FAIL hold2_lat got=%0d exp=8", c); end
        if (PP !== 8'h3C) begin n_err++; $display("FAIL hold2_pp got=%h exp=3c", PP); end
    endtask

    task automatic test_zero;
        int c;
        logic [3:0] za [2] = '{4'h0, 4'h5};
        logic [3:0] zb [2] = '{4'h9, 4'h0};
        for (int i = 0; i < 2; i++) begin
            start(za[i], zb[i]);
            wait_done(c);
            n_cmp += 3;
            if (c !== lat(za[i], zb[i])) begin n_err++; $display("FAIL zero_lat i=%0d got=%0d exp=%0d", i, c, lat(za[i], zb[i])); end
            if (PP !== 8'h00) begin n_err++; $display("FAIL zero_pp i=%0d got=%h exp=00", i, PP); end
            @(posedge clk); #1;
            if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after i=%0d got=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_ignore_init;
        int c;
        start(4'h7, 4'h7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        MA = 4'h1; MB = 4'h1; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        wait_done(c);
        n_cmp += 2;
        if (c + 3 !== 8) begin n_err++; $display("FAIL ignore_lat got=%0d exp=8", c + 3); end
        if (PP !== 8'h31) begin n_err++; $display("FAIL ignore_pp got=%h exp=31", PP); end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            n_cmp += 2;
            if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy n=%0d got=%b exp=0", n, busy); end
            if (PP !== 8'h31) begin n_err++; $display("FAIL ignore_keep n=%0d got=%h exp=31", n, PP); end
        end
    endtask

    task automatic test_mid_reset;
        int c;
        start(4'hF, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp += 4;
        if (PP !== 8'h00) begin n_err++; $display("FAIL midrst_pp got=%h exp=00", PP); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (ADD_A !== 4'h0 || ADD_B !== 4'h0) begin n_err++; $display("FAIL midrst_add got=%h/%h exp=0/0", ADD_A, ADD_B); end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle n=%0d got=%b%b exp=00", n, done, busy); end
        end
        start(4'h2, 4'h3);
        wait_done(c);
        n_cmp += 2;
        if (c !== 8) begin n_err++; $display("FAIL midrst_lat got=%0d exp=8", c); end
        if (PP !== 8'h06) begin n_err++; $display("FAIL midrst_pp2 got=%h exp=06", PP); end
    endtask

    task automatic test_random;
        int c;
        logic [3:0] a, b;
        logic [7:0] exp_pp;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if (i % 6 == 5) a = 4'h0;
            exp_pp = 8'(int'(a) * int'(b));
            start(a, b);
            wait_done(c);
            n_cmp += 2;
            if (c !== lat(a, b)) begin n_err++; $display("FAIL rand_lat %h*%h got=%0d exp=%0d", a, b, c, lat(a, b)); end
            if (PP !== exp_pp) begin n_err++; $display("FAIL rand_pp %h*%h got=%h exp=%h", a, b, PP, exp_pp); end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0) begin n_err++; $display("FAIL rand_done_pulse %h*%h got=%b exp=0", a, b, done); end
        end
    endtask

    initial begin
        test_reset;
        test_max;
        test_hold;
        test_zero;
        test_ignore_init;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult4b_seq.md
Name: mult4b_seq

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier controller.
- Sits directly upstream and downstream of the team's 4-bit ripple adder (sum4b): it drives the adder operands and consumes its 4-bit sum and carry-out.
- It iterates once per multiplier bit and produces an 8-bit product with a one-cycle done pulse.
- The adder is instantiated outside this block. Its carry-in is tied to 0 by the adder itself.

Parameters:
- None. Width is fixed at 4x4 -> 8 to match the 4-bit adder.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- init  in  1  start request, sampled only in IDLE.
- MA  in  4  multiplier operand, unsigned.
- MB  in  4  multiplicand operand, unsigned.
- ADD_A  out  4  adder operand A; equals the accumulator high nibble H.
- ADD_B  out  4  adder operand B; equals the captured multiplicand RB.
- ADD_S  in  4  adder sum.
- ADD_Co  in  1  adder carry-out.
- PP  out  8  product, registered; holds until the next completion.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Internal registers:
  - RB[3:0]: captured multiplicand.
  - H[3:0]: accumulator high nibble.
  - C: carry bit above H.
  - L[3:0]: multiplier / product low nibble.
  - cnt[1:0]: iteration counter.
  - state: 2-bit FSM state.
- Reset (rst=1 at an edge), from any state including mid-operation:
  - state=IDLE; PP=0x00; done=0; busy=0.
  - H=0; C=0; L=0; RB=0; cnt=0.
  - Any in-progress multiply is abandoned with no done pulse.
- ADD_A and ADD_B are combinational from H and RB; no other combinational paths.
- FSM states: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - If init=1: RB<=MB, L<=MA, H<=0, C<=0, cnt<=0; go to ADD.
  - Otherwise hold.
- ADD:
  - If L[0]=1: {C,H} <= {ADD_Co, ADD_S}.
  - If L[0]=0: C<=0, H unchanged.
  - Go to SHIFT.
- SHIFT:
  - {C,H,L} <= {1'b0, C, H, L[3:1]} (logical right shift of the 9-bit value).
  - cnt<=cnt+1.
  - If cnt==3 (before increment): PP <= shifted {H,L}; go to DONE.
  - Otherwise go to ADD.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency:
  - init sampled at edge k.
  - PP updates and done is high in the cycle after edge k+8.
  - busy is high from after edge k through the DONE cycle.
  - Earliest next acceptance is at edge k+10 (first cycle back in IDLE).
- init while busy (including the DONE cycle) is ignored; no queuing.
- MA/MB changes after acceptance have no effect (operands are captured).
- Arithmetic: unsigned. Maximum product 15x15=225=0xE1 fits in 8 bits; C absorbs the adder overflow before each shift.
- PP retains the last product until the next completion or reset.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: in IDLE with init=1 and (MA==0 or MB==0), go directly to DONE with PP<=0x00 at that edge. done is high in the cycle after edge k (latency 1); busy is high only for that DONE cycle.
- Not defined: zero operands take the full 8-cycle iteration and yield PP=0x00.
- Non-zero operands behave identically either way.

Test Plan:
- rst=1 for 2 cycles, then release -> PP=0x00, done=0, busy=0, ADD_A=0, ADD_B=0.
- MA=0xF, MB=0xF, init pulse at edge k -> PP=0xE1 and done=1 exactly in the cycle after edge k+8; done=0 in the cycles immediately before and after; busy=1 for 9 cycles.
- MA=0x5, MB=0x3 -> PP=0x0F. Then MA=0xA, MB=0x6 -> PP=0x3C; PP holds 0x0F until the second done.
- MA=0x0, MB=0x9:
  - Without MULT_ZERO_SKIP_EN -> PP=0x00 after 8 cycles.
  - With the macro -> PP=0x00, done in the cycle after edge k.
- Start 0x7x0x7; pulse init again at edge k+3 with MA=0x1, MB=0x1 -> ignored; PP=0x31 at the expected time.
- Start 0xFx0xF; assert rst at edge k+4 -> IDLE, PP=0x00, busy=0, no done pulse. A new init afterwards with 0x2x0x3 -> PP=0x06.
